// File: rtl/jet_sprite_render.sv
// rtl/jet_sprite_render.sv - jet sprite hit test, ROM addressing and transparency pipeline (optional JET_MIRROR_EN)
module jet_sprite_render #(
    parameter int          SPR_W       = 24,
    parameter int          SPR_H       = 20,
    parameter logic [23:0] TRANSPARENT = 24'hffffff
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        vs,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  jet_x,
    input  logic [9:0]  jet_y,
    input  logic        facing_left,
    output logic [8:0]  rom_address,
    input  logic [23:0] rom_data,
    output logic        pixel_valid,
    output logic [23:0] pixel_rgb
);

    logic        vs_d;
    logic        frame_latch;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        pos_ok;
    logic        hit;
    logic        hit1;
    logic        hit2;
    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] px11;
    logic [10:0] py11;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [10:0] col_off;
    logic [10:0] row_off;
    logic [10:0] col;
    logic [21:0] lin;
    logic [8:0]  addr;
    logic        unused_bits;

    // Falling edge of the active-low vertical sync marks the start of blanking.
    assign frame_latch = vs_d & ~vs;

    // Widen to 11 bits so pos+size never wraps and off-screen sprites clip naturally.
    assign x11   = {1'b0, DrawX};
    assign y11   = {1'b0, DrawY};
    assign px11  = {1'b0, pos_x};
    assign py11  = {1'b0, pos_y};
    assign x_end = px11 + 11'(SPR_W);
    assign y_end = py11 + 11'(SPR_H);

    assign hit = pos_ok & (x11 >= px11) & (x11 < x_end) & (y11 >= py11) & (y11 < y_end);

    assign col_off = x11 - px11;
    assign row_off = y11 - py11;

`ifdef JET_MIRROR_EN
    logic mir;
    assign col = mir ? (11'(SPR_W - 1) - col_off) : col_off;
`else
    assign col = col_off;
`endif

    // Row-major sprite index; only the low 9 bits address the ROM.
    assign lin  = 22'(row_off) * 22'(SPR_W) + 22'(col);
    assign addr = hit ? lin[8:0] : 9'd0;

    // High product bits are zero whenever hit is set; facing_left matters only when mirroring.
    assign unused_bits = ^{lin[21:9], facing_left};

    // Frame-rate state: sync edge history and the position captured once per frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vs_d   <= 1'b1;
            pos_x  <= 10'd0;
            pos_y  <= 10'd0;
            pos_ok <= 1'b0;
`ifdef JET_MIRROR_EN
            mir    <= 1'b0;
`endif
        end else begin
            vs_d <= vs;
            if (frame_latch) begin
                pos_x  <= jet_x;
                pos_y  <= jet_y;
                pos_ok <= 1'b1;
`ifdef JET_MIRROR_EN
                mir    <= facing_left;
`endif
            end
        end
    end

    // Pixel pipeline: address out in stage 1, hit delayed twice to meet the ROM's registered data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_address <= 9'd0;
            hit1        <= 1'b0;
            hit2        <= 1'b0;
        end else begin
            rom_address <= addr;
            hit1        <= hit;
            hit2        <= hit1;
        end
    end

    assign pixel_valid = hit2 & (rom_data != TRANSPARENT);
    assign pixel_rgb   = pixel_valid ? rom_data : 24'h000000;

endmodule
